// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard controller bundle: pipeline side is master, controller is slave.
// HAZ_PERF_CNT_EN adds the stall/flush cycle counters to the bundle.
interface hazard_scoreboard_if;
    logic       issue_valid;
    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used;
    logic [4:0] rd;
    logic       rd_we;
    logic       wb_we;
    logic [4:0] wb_rd;
    logic       branch_taken_e;
    logic       drain_req;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic       drain_ack, err_underflow;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    modport master (
        output issue_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_we,
        output wb_we, wb_rd, branch_taken_e, drain_req,
`ifdef HAZ_PERF_CNT_EN
        input  stall_cycles, flush_cycles,
`endif
        input  stall_f, stall_d, flush_d, flush_e, drain_ack, err_underflow
    );

    modport slave (
        input  issue_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_we,
        input  wb_we, wb_rd, branch_taken_e, drain_req,
`ifdef HAZ_PERF_CNT_EN
        output stall_cycles, flush_cycles,
`endif
        output stall_f, stall_d, flush_d, flush_e, drain_ack, err_underflow
    );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// RV32 decode-stage scoreboard: tracks in-flight register writes, drives stall/flush and drain/halt.
// Optional HAZ_PERF_CNT_EN adds free-running stall/flush cycle counters.
module hazard_scoreboard_ctrl #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave hs
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t                       state_q, state_d;
    logic [NREG-1:0][CNT_W-1:0]   pending_q, pending_d;
    logic [NREG-1:0]              uf;
    logic                         err_q;
    logic                         haz_rs1, haz_rs2, haz_sat, hazard;
    logic                         issue_acc, all_zero_d;
    logic                         stall_f, stall_d, flush_d, flush_e;

    // The last outstanding writeback resolves its own hazard (write-then-read regfile).
    assign haz_rs1 = hs.rs1_used && hs.rs1 != 5'd0 && pending_q[hs.rs1] != '0 &&
                     !(hs.wb_we && hs.wb_rd == hs.rs1 && pending_q[hs.rs1] == CNT_ONE);
    assign haz_rs2 = hs.rs2_used && hs.rs2 != 5'd0 && pending_q[hs.rs2] != '0 &&
                     !(hs.wb_we && hs.wb_rd == hs.rs2 && pending_q[hs.rs2] == CNT_ONE);
    assign haz_sat = hs.rd_we && hs.rd != 5'd0 && pending_q[hs.rd] == CNT_MAX;
    assign hazard  = hs.issue_valid && (haz_rs1 || haz_rs2 || haz_sat);

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!rst) begin
            stall_f = 1'b0;
        end else if (hs.branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (state_q != RUN || hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign issue_acc = hs.issue_valid && !stall_d && !flush_e;

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        logic inc, dec;
        assign inc = (i != 0) && issue_acc && hs.rd_we && hs.rd == 5'(i);
        assign dec = (i != 0) && hs.wb_we && hs.wb_rd == 5'(i);
        assign uf[i] = dec && !inc && pending_q[i] == '0;
        assign pending_d[i] = (inc && !dec)                    ? pending_q[i] + CNT_ONE :
                              (dec && !inc && pending_q[i] != '0) ? pending_q[i] - CNT_ONE :
                                                                  pending_q[i];
    end

    // Emptiness uses post-update counts so the final writeback halts on the same edge.
    assign all_zero_d = (pending_d == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (hs.drain_req) state_d = DRAIN;
            DRAIN:   if (!hs.drain_req) state_d = RUN;
                     else if (all_zero_d && !issue_acc) state_d = HALT;
            HALT:    if (!hs.drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            err_q     <= err_q | (|uf);
        end
    end

    assign hs.stall_f       = stall_f;
    assign hs.stall_d       = stall_d;
    assign hs.flush_d       = flush_d;
    assign hs.flush_e       = flush_e;
    assign hs.drain_ack     = rst && state_q == HALT;
    assign hs.err_underflow = rst && err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {31'd0, stall_d};
            flush_cnt_q <= flush_cnt_q + {31'd0, flush_d};
        end
    end

    assign hs.stall_cycles = stall_cnt_q;
    assign hs.flush_cycles = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Table-driven bench for hazard_scoreboard_ctrl with an expected-output queue.
module tb_hazard_scoreboard_ctrl;
    logic clk, rst;
    hazard_scoreboard_if hif();

    hazard_scoreboard_ctrl #(.NREG(32), .CNT_W(2)) dut (.clk(clk), .rst(rst), .hs(hif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_f, stall_d, flush_d, flush_e, drain_ack, err_underflow}
    localparam logic [5:0] OK  = 6'b000000;
    localparam logic [5:0] STL = 6'b110100;
    localparam logic [5:0] BRF = 6'b001100;
    localparam logic [5:0] STA = 6'b110110;
    localparam logic [5:0] BRA = 6'b001110;
    localparam logic [5:0] ERR = 6'b000001;
    localparam logic [5:0] STE = 6'b110101;

    typedef struct {
        logic       iv;
        logic [4:0] rs1; logic u1;
        logic [4:0] rs2; logic u2;
        logic [4:0] rd;  logic we;
        logic       wbwe; logic [4:0] wbrd;
        logic       br, dr;
        logic [5:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [5:0] exp_q[$];
    logic [5:0] act;
    int         checks = 0, errors = 0;
    int         exp_stall = 0, exp_flush = 0;

    assign act = {hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e, hif.drain_ack, hif.err_underflow};

    function automatic vec_t mk(logic iv, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                logic [4:0] rd, logic we, logic wbwe, logic [4:0] wbrd,
                                logic br, logic dr, logic [5:0] exp);
        vec_t v;
        v.iv = iv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.we = we;
        v.wbwe = wbwe; v.wbrd = wbrd; v.br = br; v.dr = dr; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        hif.issue_valid = v.iv;  hif.rs1 = v.rs1; hif.rs1_used = v.u1;
        hif.rs2 = v.rs2;         hif.rs2_used = v.u2;
        hif.rd = v.rd;           hif.rd_we = v.we;
        hif.wb_we = v.wbwe;      hif.wb_rd = v.wbrd;
        hif.branch_taken_e = v.br; hif.drain_req = v.dr;
    endtask

    task automatic check_out(input string nm);
        logic [5:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %b with no expected value queued", nm, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", nm, act, e);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        drive(v);
        exp_q.push_back(v.exp);
        @(negedge clk);
        check_out(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //        iv rs1 u1 rs2 u2 rd we wbwe wbrd br dr exp
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, OK));   // x0 write/read never tracked
        tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, OK));
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, OK));   // issue x5
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, STL));
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, STL));
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 1, 5, 0, 0, OK));   // released with wb x5
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, OK));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, OK));   // x7 -> 1
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, OK));   // x7 -> 2
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, OK));   // x7 -> 3
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, STL));  // saturated
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0, STL));  // wb x7 -> 2
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, OK));   // x7 -> 3
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, OK));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, OK));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, OK));
        tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, OK));   // x8 -> 1
        tbl.push_back(mk(1, 8, 1, 0, 0, 9, 1, 0, 0, 1, 0, BRF));  // branch beats hazard, no issue
        tbl.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, OK));   // x9 not pending
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, OK));  // x10 -> 1
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, OK));   // drain request
        tbl.push_back(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 1, STL));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 1, STL));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 1, STL));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, STA));  // halted
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, BRA));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STA));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OK));   // back in RUN
        tbl.push_back(mk(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 1, OK));  // x12 -> 1, enter DRAIN
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL));  // abort drain
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OK));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, OK));
        tbl.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, OK));  // x13 -> 1
        tbl.push_back(mk(1, 13, 0, 13, 0, 0, 0, 0, 0, 0, 0, OK)); // unused sources ignored
        tbl.push_back(mk(1, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, STL));
        tbl.push_back(mk(1, 0, 0, 13, 1, 0, 0, 1, 13, 0, 0, OK));

        rst = 1'b0;
        drive(mk(1, 5, 1, 5, 1, 5, 1, 1, 5, 1, 1, OK));
        #2;
        exp_q.push_back(OK);
        check_out("reset_outputs");
        @(posedge clk); @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OK));
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            exp_stall += int'(tbl[i].exp[4]);
            exp_flush += int'(tbl[i].exp[3]);
            apply(tbl[i], $sformatf("vec%0d", i));
        end

`ifdef HAZ_PERF_CNT_EN
        checks++;
        if (hif.stall_cycles !== 32'(exp_stall)) begin
            errors++;
            $display("FAIL stall_cycles: got %0d expected %0d", hif.stall_cycles, exp_stall);
        end
        checks++;
        if (hif.flush_cycles !== 32'(exp_flush)) begin
            errors++;
            $display("FAIL flush_cycles: got %0d expected %0d", hif.flush_cycles, exp_flush);
        end
`endif

        // underflow is sticky, then reset lands in the middle of a stall
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, OK),   "uf_wb");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ERR),  "uf_set");
        apply(mk(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, ERR), "uf_hold");
        apply(mk(1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, STE), "uf_stall");
        drive(mk(1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, OK));
        @(negedge clk);
        exp_q.push_back(STE);
        check_out("pre_reset_stall");
        #1 rst = 1'b0;
        #1;
        exp_q.push_back(OK);
        check_out("mid_reset_stall");
        hif.branch_taken_e = 1'b1;
        #1;
        exp_q.push_back(OK);
        check_out("mid_reset_branch");
        @(posedge clk); #1;
        rst = 1'b1;
        apply(mk(1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, OK), "post_reset_clear");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OK),  "post_reset_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
